knight_cmd_link: RTL
====================

// Module: knight_cmd_link
// PURPOSE
//  Knight-side end of the remote command link: the UART receiver that turns 2-byte frames
//  from the remote into one 16-bit command, and the UART transmitter that returns the
//  1-byte response (0xA5 = positive ack). Sits between the RX/TX pins and the command FSM.
// PARAMETERS
//  BAUD_DIV      2604    clks per UART bit (50 MHz / 19200 baud); must be >= 4
//  TIMEOUT_CLKS  2500000 max clks between end of high byte and low-byte start (BYTE_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  RX           in   1   serial in, idle high, asynchronous to clk
//  TX           out  1   serial out, idle high
//  cmd          out  16  assembled command {high byte, low byte}
//  cmd_rdy      out  1   level: a complete cmd is valid
//  clr_cmd_rdy  in   1   consumer pulse: clears cmd_rdy
//  resp         in   8   response byte to send
//  snd_resp     in   1   pulse: start sending resp
//  resp_sent    out  1   level: last response fully shifted out
//  tx_busy      out  1   transmitter is mid-frame
// BEHAVIOUR
//  Reset: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0; both shifters idle, FSM=IDLE.
//  Reset mid-frame aborts everything; partial bytes discarded; TX high the next cycle.
//  RX path: RX double-flopped before use. Start = synced RX low while idle. Sample mid-bit:
//   first sample BAUD_DIV/2 clks after start edge, then every BAUD_DIV. 1 start, 8 data
//   LSB first, 1 stop. Start sample high -> false start, return to idle. Stop sample low ->
//   framing error, byte dropped, frame FSM unchanged. Byte valid = 1-clk internal strobe at
//   the stop sample.
//  Frame FSM: IDLE --byte--> HIGH (latch byte into cmd_hi; cmd_rdy cleared same edge)
//   HIGH --byte--> IDLE (cmd <= {cmd_hi, byte}; cmd_rdy <= 1 on the same edge).
//   cmd changes only on low-byte completion; cmd_hi is internal.
//   cmd_rdy stays high until clr_cmd_rdy or next high byte. Set and clr in same clk: set wins.
//  TX path: snd_resp with tx_busy=0 -> next clk tx_busy=1, resp_sent=0, resp latched, TX=0
//   (start) for BAUD_DIV clks, then 8 data LSB first, then stop (1) for BAUD_DIV clks.
//   End of stop bit: tx_busy=0, resp_sent=1 same edge. Full frame = 10*BAUD_DIV clks.
//   snd_resp while tx_busy=1 ignored (no queue); resp changes after latch ignored.
//  RX and TX fully independent (full duplex); a response may be sent mid-command.
//  All counters saturate-free: baud counter wraps to 0 at BAUD_DIV-1, bit counter 0..9.
// CONFIGURATION
//  BYTE_TIMEOUT_EN defined: counter starts on entering HIGH, clears on next RX start edge;
//   reaching TIMEOUT_CLKS in HIGH -> drop cmd_hi, go IDLE, cmd/cmd_rdy untouched. A
//   subsequent byte is treated as a new high byte (resynchronises a lost byte).
//  Not defined: FSM waits in HIGH indefinitely; no timeout counter synthesised.
// TESTING (BAUD_DIV=16 for sim speed)
//  1. Remote sends 0x43 then 0xF1 -> cmd=16'h43F1, cmd_rdy rises at low-byte stop sample;
//     clr_cmd_rdy pulse -> cmd_rdy=0 next clk, cmd holds 16'h43F1.
//  2. snd_resp with resp=8'hA5 -> TX=0,1,0,1,0,0,1,0,1,1 each 16 clks; resp_sent=1 after
//     160 clks; second snd_resp at clk 50 ignored, same waveform.
//  3. First byte 0x12 with stop bit forced low, then 0x34,0x56 -> cmd=16'h3456, no 0x12
//     anywhere; cmd_rdy set once.
//  4. clr_cmd_rdy asserted on exact low-byte completion clk of 0xBEEF -> cmd_rdy=1.
//  5. rst asserted mid high byte, then 0xAB,0xCD -> cmd=16'hABCD; TX high throughout;
//     rst mid-TX -> TX=1, tx_busy=0 next clk.
//  6. BYTE_TIMEOUT_EN, TIMEOUT_CLKS=1000: send 0x11, idle 1200 clks, send 0x22,0x33 ->
//     cmd=16'h2233; without macro same stimulus -> cmd=16'h1122.

Source files
------------

// File: rtl/knight_cmd_link.sv
// Remote command link: UART RX assembles 2-byte frames into a 16-bit cmd; UART TX returns a 1-byte response.
// Latency: cmd/cmd_rdy update on the low-byte stop sample; a response frame takes 10*BAUD_DIV clks after snd_resp.
// Backpressure: none; cmd_rdy is a level cleared by clr_cmd_rdy, snd_resp while tx_busy is dropped. Optional: BYTE_TIMEOUT_EN.
module knight_cmd_link #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic        resp_sent,
    output logic        tx_busy
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic {FR_IDLE, FR_HIGH} fr_state_t;

    logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    rx_state_t       rx_state_q, rx_state_d;
    logic [BW-1:0]   rx_baud_q, rx_baud_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_sample;
    logic            byte_vld;

    fr_state_t       fr_state_q, fr_state_d;
    logic [7:0]      cmd_hi_q, cmd_hi_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    logic            tx_q, tx_d;
    logic            tx_busy_q, tx_busy_d;
    logic            resp_sent_q, resp_sent_d;
    logic [BW-1:0]   tx_baud_q, tx_baud_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;

`ifdef BYTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            rx_start;
    logic            to_hit;
    assign rx_start = (rx_state_q == RX_IDLE) && !rx_s2_q;
    assign to_hit   = (fr_state_q == FR_HIGH) && (to_cnt_q == TW'(TIMEOUT_CLKS - 1));
`endif

    // RX synchroniser and bit-level receiver: mid-bit sampling, start/stop validation.
    always_comb begin
        rx_s1_d    = RX;
        rx_s2_d    = rx_s1_q;
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_sample  = 1'b0;
        byte_vld   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_DATA;
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                // First sample lands half a bit after the start edge, later ones a full bit apart.
                rx_sample = (rx_bit_q == 4'd0) ? (rx_baud_q == BAUD_HALF) : (rx_baud_q == BAUD_LAST);
                if (!rx_sample) begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end else begin
                    rx_baud_d = '0;
                    rx_bit_d  = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd0) begin
                        if (rx_s2_q) rx_state_d = RX_IDLE;
                    end else if (rx_bit_q == 4'd9) begin
                        rx_bit_d = '0;
                        if (rx_s2_q) begin
                            byte_vld   = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            // Low stop bit: hold off until the line goes high again so the
                            // rest of a break is not mistaken for a fresh start bit.
                            rx_state_d = RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame assembly: first byte is held as cmd_hi, second completes cmd and raises cmd_rdy.
    always_comb begin
        fr_state_d = fr_state_q;
        cmd_hi_d   = cmd_hi_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q & ~clr_cmd_rdy;
`ifdef BYTE_TIMEOUT_EN
        to_cnt_d   = (fr_state_q == FR_HIGH && rx_state_q == RX_IDLE) ? to_cnt_q + 1'b1 : to_cnt_q;
        if (rx_start || fr_state_q != FR_HIGH) to_cnt_d = '0;
        // A stale high byte is dropped so the next byte resynchronises as a new high byte.
        if (to_hit && !byte_vld) fr_state_d = FR_IDLE;
`endif
        if (byte_vld) begin
            if (fr_state_q == FR_IDLE) begin
                fr_state_d = FR_HIGH;
                cmd_hi_d   = rx_shift_q;
                cmd_rdy_d  = 1'b0;
            end else begin
                fr_state_d = FR_IDLE;
                cmd_d      = {cmd_hi_q, rx_shift_q};
                cmd_rdy_d  = 1'b1;
            end
        end
    end

    // Transmitter: start, 8 data LSB first, stop; each bit held BAUD_DIV clks.
    always_comb begin
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        resp_sent_d = resp_sent_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        if (!tx_busy_q) begin
            if (snd_resp) begin
                tx_busy_d   = 1'b1;
                resp_sent_d = 1'b0;
                tx_shift_d  = resp;
                tx_d        = 1'b0;
                tx_baud_d   = '0;
                tx_bit_d    = '0;
            end
        end else if (tx_baud_q == BAUD_LAST) begin
            tx_baud_d = '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_d   = 1'b0;
                resp_sent_d = 1'b1;
                tx_d        = 1'b1;
                tx_bit_d    = '0;
            end else begin
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q < 4'd8) begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_d = 1'b1;
                end
            end
        end else begin
            tx_baud_d = tx_baud_q + 1'b1;
        end
    end

    // State registers; reset aborts any partial RX byte or TX frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_baud_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            fr_state_q  <= FR_IDLE;
            cmd_hi_q    <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
`ifdef BYTE_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            fr_state_q  <= fr_state_d;
            cmd_hi_q    <= cmd_hi_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            resp_sent_q <= resp_sent_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
`ifdef BYTE_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;
    assign tx_busy   = tx_busy_q;
endmodule
